// File: rtl/spi_rxc_fifo.sv
// SPI receive core: serial frame assembly, receive FIFO, optional CRC.
// Optional CRC frame checking is enabled by defining SPI_RX_CRC_EN.
module spi_rxc_fifo #(
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TNUM_W     = 13,
  localparam int FLW       = $clog2(DW),
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_rx,
  input  logic              spi_rx_rstn,
  input  logic              rx_en,
  input  logic              shift_in,
  input  logic [FLW-1:0]    frame_len,
  input  logic [TNUM_W-1:0] spi_tnum_max,
  input  logic              lsbf,
  input  logic              crc_en,
  input  logic [DW-1:0]     crc_poly,
  input  logic [DW-1:0]     crc_init,
  input  logic              ovf_clr,
  output logic [DW-1:0]     rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [LW-1:0]     fifo_level,
  output logic              rx_busy,
  output logic              rx_num_max_en,
  output logic [DW-1:0]     rx_crc_data_out,
  output logic              rx_crc_done,
  output logic              rx_crc_err,
  output logic              rx_ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] CRC  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state_q;
  logic [FLW-1:0]    bit_cnt_q;
  logic [FLW-1:0]    flen_q;
  logic              lsbf_q;
  logic [TNUM_W-1:0] frame_cnt_q;
  logic [DW-1:0]     word_q;
  logic [DW-1:0]     word_nxt;
  logic              lsb_eff;
  logic              in_frame;
  logic              frame_done;
  logic              push;
  logic              last;
  logic              go_crc;
  logic              num_max_q;

  logic [DW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [LW-1:0]     cnt_q;
  logic              full;
  logic              pop;
  logic              do_push;
  logic              ovf_q;

  // The IDLE edge uses live settings; later bits use the latched ones.
  assign lsb_eff = (state_q == IDLE) ? lsbf : lsbf_q;

  // Next assembled word including the bit on this edge.
  always_comb begin
    word_nxt = word_q;
    if (lsb_eff)
      word_nxt = word_q | (DW'(shift_in) << bit_cnt_q);
    else
      word_nxt = {word_q[DW-2:0], shift_in};
  end

  assign in_frame   = (state_q == DATA) || (state_q == CRC);
  assign frame_done = rx_en && in_frame && (bit_cnt_q == flen_q);
  assign push       = frame_done && (state_q == DATA);
  assign last       = push && (frame_cnt_q == spi_tnum_max);

  // Transfer FSM, bit/frame counters and word assembly.
  always_ff @(posedge clk_rx) begin
    if (!spi_rx_rstn) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      flen_q      <= '0;
      lsbf_q      <= 1'b0;
      frame_cnt_q <= '0;
      word_q      <= '0;
      num_max_q   <= 1'b0;
    end else begin
      num_max_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_en) begin
            state_q     <= DATA;
            flen_q      <= frame_len;
            lsbf_q      <= lsbf;
            frame_cnt_q <= '0;
            bit_cnt_q   <= FLW'(1);
            word_q      <= word_nxt;
          end
        end
        DATA, CRC: begin
          if (rx_en) begin
            if (frame_done) begin
              bit_cnt_q <= '0;
              word_q    <= '0;
              if (state_q == CRC) begin
                state_q <= DONE;
              end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
                if (last) begin
                  num_max_q <= 1'b1;
                  state_q   <= go_crc ? CRC : DONE;
                end
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              word_q    <= word_nxt;
            end
          end
        end
        DONE: begin
          if (!rx_en)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_busy       = in_frame;
  assign rx_num_max_en = num_max_q;

`ifdef SPI_RX_CRC_EN
  logic          crc_en_q;
  logic [DW-1:0] poly_q;
  logic [DW-1:0] crc_q;
  logic          crc_done_q;
  logic          crc_err_q;

  function automatic logic [DW-1:0] fmask(
    input logic [FLW-1:0] fl
  );
    return {DW{1'b1}} >> (FLW'(DW - 1) - fl);
  endfunction

  function automatic logic [DW-1:0] crc_step(
    input logic [DW-1:0]  c,
    input logic           b,
    input logic [DW-1:0]  p,
    input logic [FLW-1:0] fl
  );
    logic fb;
    fb = b ^ c[fl];
    return ((c << 1) ^ (fb ? p : '0)) & fmask(fl);
  endfunction

  assign go_crc = crc_en_q;

  // Serial CRC over data bits and comparison against the CRC frame.
  always_ff @(posedge clk_rx) begin
    if (!spi_rx_rstn) begin
      crc_en_q   <= 1'b0;
      poly_q     <= '0;
      crc_q      <= '0;
      crc_done_q <= 1'b0;
      crc_err_q  <= 1'b0;
    end else begin
      crc_done_q <= 1'b0;
      if (state_q == IDLE && rx_en) begin
        crc_en_q  <= crc_en;
        poly_q    <= crc_poly & fmask(frame_len);
        crc_err_q <= 1'b0;
        crc_q     <= crc_step(crc_init & fmask(frame_len),
                              shift_in,
                              crc_poly & fmask(frame_len),
                              frame_len);
      end else if (state_q == DATA && rx_en) begin
        crc_q <= crc_step(crc_q, shift_in, poly_q, flen_q);
      end else if (frame_done) begin
        crc_done_q <= 1'b1;
        if (word_nxt != crc_q)
          crc_err_q <= 1'b1;
      end
    end
  end

  assign rx_crc_data_out = crc_q;
  assign rx_crc_done     = crc_done_q;
  assign rx_crc_err      = crc_err_q;
`else
  logic unused_crc;

  assign unused_crc      = ^{crc_en, crc_poly, crc_init};
  assign go_crc          = 1'b0;
  assign rx_crc_data_out = '0;
  assign rx_crc_done     = 1'b0;
  assign rx_crc_err      = 1'b0;
`endif

  assign full    = (cnt_q == LW'(FIFO_DEPTH));
  assign pop     = rx_valid && rx_ready;
  assign do_push = push && (!full || pop);

  // FIFO storage; contents are don't-care while not counted.
  always_ff @(posedge clk_rx) begin
    if (do_push)
      mem[wptr_q] <= word_nxt;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk_rx) begin
    if (!spi_rx_rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push)
        wptr_q <= wptr_q + 1'b1;
      if (pop)
        rptr_q <= rptr_q + 1'b1;
      case ({do_push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (push && full && !pop)
        ovf_q <= 1'b1;
      else if (ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  assign rx_valid   = (cnt_q != '0);
  assign rx_data    = rx_valid ? mem[rptr_q] : '0;
  assign fifo_level = cnt_q;
  assign rx_ovf     = ovf_q;

endmodule

// File: tb/tb_spi_rxc_fifo.sv
// Directed bench for spi_rxc_fifo with a scoreboard of expected frames.
// CRC checks follow SPI_RX_CRC_EN, matching the DUT build.
module tb_spi_rxc_fifo;

  logic        clk_rx = 1'b0;
  logic        spi_rx_rstn;
  logic        rx_en;
  logic        shift_in;
  logic [4:0]  frame_len;
  logic [12:0] spi_tnum_max;
  logic        lsbf;
  logic        crc_en;
  logic [31:0] crc_poly;
  logic [31:0] crc_init;
  logic        ovf_clr;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [2:0]  fifo_level;
  logic        rx_busy;
  logic        rx_num_max_en;
  logic [31:0] rx_crc_data_out;
  logic        rx_crc_done;
  logic        rx_crc_err;
  logic        rx_ovf;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  spi_rxc_fifo dut (
    .clk_rx          (clk_rx),
    .spi_rx_rstn     (spi_rx_rstn),
    .rx_en           (rx_en),
    .shift_in        (shift_in),
    .frame_len       (frame_len),
    .spi_tnum_max    (spi_tnum_max),
    .lsbf            (lsbf),
    .crc_en          (crc_en),
    .crc_poly        (crc_poly),
    .crc_init        (crc_init),
    .ovf_clr         (ovf_clr),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .fifo_level      (fifo_level),
    .rx_busy         (rx_busy),
    .rx_num_max_en   (rx_num_max_en),
    .rx_crc_data_out (rx_crc_data_out),
    .rx_crc_done     (rx_crc_done),
    .rx_crc_err      (rx_crc_err),
    .rx_ovf          (rx_ovf)
  );

  always #5 clk_rx = ~clk_rx;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_rx);
    #1;
  endtask

  task automatic idle(input int n);
    rx_en    = 1'b0;
    shift_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Send bits [from, to) of an n-bit frame in wire order.
  task automatic send_bits(input logic [31:0] val,
                           input int n, input bit lsb,
                           input int from, input int to);
    for (int i = from; i < to; i++) begin
      rx_en    = 1'b1;
      shift_in = lsb ? val[i] : val[n-1-i];
      tick();
    end
  endtask

  task automatic send_frame(input logic [31:0] val,
                            input int n, input bit lsb);
    send_bits(val, n, lsb, 0, n);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    chk({tag, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD;
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    chk({tag, "_data"}, rx_data, e);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    spi_rx_rstn  = 1'b0;
    rx_en        = 1'b0;
    shift_in     = 1'b0;
    frame_len    = 5'd7;
    spi_tnum_max = '0;
    lsbf         = 1'b0;
    crc_en       = 1'b0;
    crc_poly     = '0;
    crc_init     = '0;
    ovf_clr      = 1'b0;
    rx_ready     = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_busy", 32'(rx_busy), 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ovf", 32'(rx_ovf), 0);
    spi_rx_rstn = 1'b1;

    // 8-bit MSB-first
    exp_q.push_back(32'h000000A5);
    send_bits(32'hA5, 8, 1'b0, 0, 7);
    chk("t1_busy_mid", 32'(rx_busy), 1);
    chk("t1_valid_mid", 32'(rx_valid), 0);
    send_bits(32'hA5, 8, 1'b0, 7, 8);
    chk("t1_valid", 32'(rx_valid), 1);
    chk("t1_nummax", 32'(rx_num_max_en), 1);
    chk("t1_busy_end", 32'(rx_busy), 0);
    idle(1);
    chk("t1_nummax_off", 32'(rx_num_max_en), 0);
    pop_check("t1");

    // 16-bit LSB-first with a 3-edge stall
    frame_len = 5'd15;
    lsbf      = 1'b1;
    exp_q.push_back(32'h0000B971);
    send_bits(32'hB971, 16, 1'b1, 0, 8);
    idle(3);
    chk("t2_busy_stall", 32'(rx_busy), 1);
    chk("t2_valid_stall", 32'(rx_valid), 0);
    send_bits(32'hB971, 16, 1'b1, 8, 16);
    idle(1);
    chk("t2_level", 32'(fifo_level), 1);
    pop_check("t2");

    // 12-bit, three frames, no pops
    frame_len    = 5'd11;
    lsbf         = 1'b0;
    spi_tnum_max = 13'd2;
    exp_q.push_back(32'hABC);
    exp_q.push_back(32'h123);
    exp_q.push_back(32'hFFF);
    send_frame(32'hABC, 12, 1'b0);
    chk("t3_nummax_f0", 32'(rx_num_max_en), 0);
    send_frame(32'h123, 12, 1'b0);
    send_frame(32'hFFF, 12, 1'b0);
    chk("t3_nummax", 32'(rx_num_max_en), 1);
    idle(1);
    chk("t3_level", 32'(fifo_level), 3);
    pop_check("t3a");
    pop_check("t3b");
    pop_check("t3c");
    chk("t3_level_end", 32'(fifo_level), 0);

    // Overflow: five frames into a 4-deep FIFO
    frame_len    = 5'd7;
    spi_tnum_max = 13'd4;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(32'(k));
      send_frame(32'(k), 8, 1'b0);
    end
    idle(1);
    chk("t4_ovf", 32'(rx_ovf), 1);
    chk("t4_level", 32'(fifo_level), 4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(rx_ovf), 0);
    pop_check("t4a");
    pop_check("t4b");
    pop_check("t4c");
    pop_check("t4d");

    // CRC-8, poly 0x07, init 0, data 0xA1
    spi_tnum_max = '0;
    crc_en       = 1'b1;
    crc_poly     = 32'h07;
    crc_init     = 32'h0;
`ifdef SPI_RX_CRC_EN
    exp_q.push_back(32'hA1);
    send_frame(32'hA1, 8, 1'b0);
    chk("t5_nummax", 32'(rx_num_max_en), 1);
    chk("t5_busy_crc", 32'(rx_busy), 1);
    chk("t5_crc", rx_crc_data_out, 32'h6E);
    send_frame(32'h6E, 8, 1'b0);
    chk("t5_done", 32'(rx_crc_done), 1);
    chk("t5_err", 32'(rx_crc_err), 0);
    chk("t5_busy_end", 32'(rx_busy), 0);
    idle(1);
    chk("t5_done_off", 32'(rx_crc_done), 0);
    pop_check("t5");
    exp_q.push_back(32'hA1);
    send_frame(32'hA1, 8, 1'b0);
    send_frame(32'h6F, 8, 1'b0);
    chk("t5_done2", 32'(rx_crc_done), 1);
    chk("t5_err2", 32'(rx_crc_err), 1);
    idle(1);
    chk("t5_err_sticky", 32'(rx_crc_err), 1);
`else
    exp_q.push_back(32'hA1);
    send_frame(32'hA1, 8, 1'b0);
    chk("t5_nummax", 32'(rx_num_max_en), 1);
    chk("t5_busy_nocrc", 32'(rx_busy), 0);
    chk("t5_crc_zero", rx_crc_data_out, 0);
    chk("t5_done_zero", 32'(rx_crc_done), 0);
    chk("t5_err_zero", 32'(rx_crc_err), 0);
    idle(1);
`endif
    crc_en = 1'b0;

    // Reset mid-frame with one entry still queued
    chk("t6_level_pre", 32'(fifo_level), 1);
    send_bits(32'h3C, 8, 1'b0, 0, 5);
    chk("t6_busy_pre", 32'(rx_busy), 1);
    spi_rx_rstn = 1'b0;
    rx_en       = 1'b0;
    tick();
    spi_rx_rstn = 1'b1;
    exp_q.delete();
    chk("t6_busy", 32'(rx_busy), 0);
    chk("t6_valid", 32'(rx_valid), 0);
    chk("t6_level", 32'(fifo_level), 0);
    chk("t6_data", rx_data, 0);
    chk("t6_crc_err", 32'(rx_crc_err), 0);
    chk("t6_crc_out", rx_crc_data_out, 0);
    chk("t6_nummax", 32'(rx_num_max_en), 0);
    exp_q.push_back(32'h3C);
    send_frame(32'h3C, 8, 1'b0);
    chk("t6_nummax_new", 32'(rx_num_max_en), 1);
    idle(1);
    pop_check("t6");
    chk("t6_sb_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_rxc_fifo.md
# spi_rxc_fifo

Parametrised next-generation SPI receive core. Shifts serial data in on `clk_rx`, assembles frames of programmable length (4..DW bits, MSB- or LSB-first), and counts frames per transfer. Completed frames are buffered in an internal FIFO and delivered through a valid/ready interface. An optional trailing CRC frame is received and checked against an on-the-fly serial CRC. It sits between the SPI pin/clock-gating logic and the register/DMA read path.

## Interface
- `DW`, 32: maximum frame width in bits; ≥ 8.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of 2, ≥ 2.
- `TNUM_W`, 13: width of the frame counter.
- `clk_rx` in 1: receive shift clock; all logic is on its rising edge.
- `spi_rx_rstn` in 1: reset. Synchronous, active-low.
- `rx_en` in 1: a bit is consumed on every rising edge where this is 1.
- `shift_in` in 1: serial data bit.
- `frame_len` in $clog2(DW): frame bits minus 1. Legal range 3..DW-1.
- `spi_tnum_max` in TNUM_W: data frames per transfer minus 1.
- `lsbf` in 1: 1 = LSB first.
- `crc_en` in 1: 1 = a CRC frame follows the last data frame.
- `crc_poly` in DW: polynomial; only the low frame_len+1 bits are used.
- `crc_init` in DW: CRC seed, masked the same way.
- `ovf_clr` in 1: clears `rx_ovf`.
- `rx_data` out DW: FIFO head, right-justified, upper bits 0.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: pops the head when `rx_valid` is also 1.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `rx_busy` out 1: 1 in DATA and CRC states.
- `rx_num_max_en` out 1: one-cycle pulse when the last data frame completes.
- `rx_crc_data_out` out DW: computed CRC (masked).
- `rx_crc_done` out 1: one-cycle pulse when the CRC frame completes.
- `rx_crc_err` out 1: sticky mismatch flag.
- `rx_ovf` out 1: sticky overflow flag.

## Operation
- **FSM states:** IDLE, DATA, CRC, DONE. Reset enters IDLE.
- **IDLE → DATA:** taken on the first edge with `rx_en`=1.
  - That edge's `shift_in` is bit 0 of the frame.
  - `frame_len`, `lsbf`, `crc_en`, `crc_poly` and `crc_init` are latched on this edge and held for the whole transfer.
  - On this edge the CRC register loads `crc_init`, then processes the bit.
  - `rx_crc_err` is cleared.
- **DATA:** `bit_cnt` increments on each edge with `rx_en`=1. Edges with `rx_en`=0 stall the FSM; no state changes.
- **Frame completion:** when `bit_cnt`==`frame_len`:
  - the assembled word is pushed to the FIFO;
  - `bit_cnt` is cleared and `frame_cnt` is incremented.
- **Last data frame:** when `frame_cnt`==`spi_tnum_max`, `rx_num_max_en` pulses. The FSM then goes to CRC if `crc_en`, otherwise to DONE.
- **Assembly:**
  - MSB-first: `word = {word, shift_in}`.
  - LSB-first: `word[bit_cnt] = shift_in`.
  - Unused upper bits are 0.
- **CRC update** (DATA bits only), with n = frame_len+1:
  - `fb = shift_in ^ crc[n-1]`;
  - `crc = ((crc<<1) ^ (fb ? poly : 0)) & mask(n)`.
- **CRC state:** assembles one frame with identical rules. The frame is not pushed to the FIFO and does not update the CRC register. On completion:
  - `rx_crc_done` pulses;
  - `rx_crc_err` is set if the received frame ≠ `rx_crc_data_out`;
  - the FSM goes to DONE.
- **DONE:** returns to IDLE on the first edge with `rx_en`=0. Bits arriving while in DONE with `rx_en`=1 are ignored.
- **FIFO full:**
  - A push with the FIFO full and no pop drops the frame and sets `rx_ovf`. Stored data is unchanged.
  - A push and a pop on the same edge while full are both accepted; the level is unchanged.
  - A push and a pop on the same edge while empty leave the level at 1, because `rx_valid` was 0 and no pop occurred.
- **Sticky flags:** `rx_ovf` is cleared by `ovf_clr`; a set on the same edge wins. `rx_crc_err` is cleared only at transfer start or by reset.
- **Frame counter width:** `frame_cnt` is TNUM_W bits wide, so up to 2^TNUM_W frames per transfer are supported.

## Timing
- **Reset:** with `spi_rx_rstn`=0 at a rising edge, all outputs are 0, the FIFO is emptied, and the FSM enters IDLE. This applies mid-frame too; the partial frame is discarded.
- **Frame-to-FIFO latency:** the last bit is sampled at edge N. `rx_valid` and `rx_data` are valid after edge N.
- **Pulse timing:** `rx_num_max_en` and `rx_crc_done` are high for exactly the cycle following the completing edge.
- **Busy:** `rx_busy` rises after the IDLE→DATA edge and falls after the edge that enters DONE.
- **Pop:** takes effect on the edge where `rx_valid` and `rx_ready` are both 1. The next entry is presented after that edge.

## Configuration
- **`SPI_RX_CRC_EN` defined:** CRC logic, the CRC state, and the `rx_crc_*` outputs are functional as described above.
- **`SPI_RX_CRC_EN` undefined:**
  - `crc_en` is ignored and the last data frame always goes to DONE;
  - `rx_crc_data_out`, `rx_crc_done` and `rx_crc_err` are tied to 0;
  - no CRC registers are synthesised.

## Test plan
- **8-bit MSB-first:** frame_len=7, tnum_max=0, send 0xA5 MSB-first → `rx_data`=0x000000A5, `rx_valid` after the 8th edge, `rx_num_max_en` pulse, `rx_busy` 1→0.
- **16-bit LSB-first, stalls:** frame_len=15, lsbf=1, send 0xB971 with `rx_en` low for 3 edges mid-frame → `rx_data`=0x0000B971.
- **Odd width, multi-frame:** frame_len=11, tnum_max=2, send 0xABC, 0x123, 0xFFF with `rx_ready`=0 → `fifo_level`=3. Then pop three → 0xABC, 0x123, 0xFFF in order.
- **Overflow:** FIFO_DEPTH=4, `rx_ready`=0, send 5 frames of 8 bits (0x01..0x05) → `rx_ovf`=1, FIFO holds 0x01..0x04. `ovf_clr` → `rx_ovf`=0.
- **CRC-8:** frame_len=7, crc_poly=0x07, crc_init=0, crc_en=1, send data 0xA1 → `rx_crc_data_out`=0x6E.
  - CRC frame 0x6E → `rx_crc_done` pulse, `rx_crc_err`=0.
  - Repeat with CRC frame 0x6F → `rx_crc_err`=1.
- **Reset mid-frame:** after 5 bits of a frame, drive `spi_rx_rstn`=0 for one edge → all outputs 0, FSM in IDLE. A fresh 0x3C is then received correctly.
